// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and small helpers for the ST7789V3 init sequencer.
// Init ROM entries are {kind[1:0], payload[7:0]}.
package lcd_pkg;

    localparam int ENTRY_W = 10;

    localparam logic [1:0] KIND_CMD   = 2'b00;
    localparam logic [1:0] KIND_DATA  = 2'b01;
    localparam logic [1:0] KIND_DELAY = 2'b10;
    localparam logic [1:0] KIND_END   = 2'b11;

    localparam logic [7:0] SWRESET = 8'h01;
    localparam logic [7:0] SLPOUT  = 8'h11;
    localparam logic [7:0] COLMOD  = 8'h3A;
    localparam logic [7:0] MADCTL  = 8'h36;
    localparam logic [7:0] INVON   = 8'h21;
    localparam logic [7:0] DISPON  = 8'h29;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_LO,
        ST_RST_WAIT,
        ST_FETCH,
        ST_SEND,
        ST_WAIT_MS,
        ST_READY
    } seq_state_e;

    // Down-counters exit on zero, so an N-cycle wait loads N-1.
    function automatic logic [31:0] cycles_to_load(input logic [31:0] n);
        return (n == 32'd0) ? 32'd0 : n - 32'd1;
    endfunction

    function automatic logic [31:0] sat_mul(input logic [7:0] a, input logic [31:0] b);
        logic [39:0] p;
        p = 40'(a) * 40'(b);
        return (|p[39:32]) ? 32'hFFFF_FFFF : p[31:0];
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Synchronous-read init ROM for the ST7789V3 bring-up sequence.
// Unused addresses read as END so a short table always terminates.
module lcd_init_rom
    import lcd_pkg::*;
#(
    parameter int ROM_AW = 5
) (
    input  logic                clk,
    input  logic [ROM_AW-1:0]   addr,
    output logic [ENTRY_W-1:0]  entry
);

    function automatic logic [ENTRY_W-1:0] rom_word(input int unsigned idx);
        case (idx)
            0:       return {KIND_CMD,   SLPOUT};
            1:       return {KIND_DELAY, 8'd120};
            2:       return {KIND_CMD,   COLMOD};
            3:       return {KIND_DATA,  8'h55};
            4:       return {KIND_CMD,   MADCTL};
            5:       return {KIND_DATA,  8'h00};
            6:       return {KIND_CMD,   INVON};
            7:       return {KIND_CMD,   DISPON};
            8:       return {KIND_DELAY, 8'd10};
            default: return {KIND_END,   8'h00};
        endcase
    endfunction

    always_ff @(posedge clk) begin
        entry <= rom_word(32'(addr));
    end

endmodule

// File: rtl/lcd_init_sequencer.sv
// ST7789V3 bring-up sequencer: reset pulse, init ROM walk, then pixel pass-through.
// Define LCD_SEQ_DELAY_EN for full-length RST_WAIT/DELAY waits; otherwise each lasts one cycle.
module lcd_init_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned RST_LOW_CYC  = 140,
    parameter int unsigned RST_WAIT_CYC = 1_680_000,
    parameter int unsigned MS_CYC       = 14_000,
    parameter int          ROM_AW       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       lcd_rst,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_dc,
    input  logic       px_valid,
    output logic       px_ready,
    input  logic [7:0] px_byte,
    output logic       busy,
    output logic       done
);

    seq_state_e          state_q;
    logic [31:0]         cnt_q;
    logic [ROM_AW-1:0]   addr_q;
    logic [ROM_AW-1:0]   addr_d;
    logic                lcd_rst_q;
    logic                valid_q;
    logic [7:0]          byte_q;
    logic                dc_q;
    logic                busy_q;
    logic                done_q;

    logic [ENTRY_W-1:0]  entry;
    logic [1:0]          kind;
    logic [7:0]          payload;
    logic [31:0]         delay_cyc;
    logic                at_last;
    logic                wait_rst_done;
    logic                wait_ms_done;
    logic                delay_skip;
    logic                step;

    // The ROM is addressed with next-state so FETCH already sees the entry at addr_q.
    lcd_init_rom #(
        .ROM_AW (ROM_AW)
    ) u_rom (
        .clk   (clk),
        .addr  (addr_d),
        .entry (entry)
    );

    assign kind      = entry[ENTRY_W-1 -: 2];
    assign payload   = entry[7:0];
    assign delay_cyc = sat_mul(payload, 32'(MS_CYC));
    assign at_last   = (addr_q == {ROM_AW{1'b1}});

`ifdef LCD_SEQ_DELAY_EN
    assign wait_rst_done = (cnt_q == 32'd0);
    assign wait_ms_done  = (cnt_q == 32'd0);
    assign delay_skip    = (delay_cyc == 32'd0);
`else
    assign wait_rst_done = 1'b1;
    assign wait_ms_done  = 1'b1;
    assign delay_skip    = 1'b0;
`endif

    assign step = ((state_q == ST_SEND)    && tx_ready)     ||
                  ((state_q == ST_WAIT_MS) && wait_ms_done) ||
                  ((state_q == ST_FETCH)   && (kind == KIND_DELAY) && delay_skip);

    // Address stops at the last entry; the FSM turns that step into READY.
    always_comb begin
        addr_d = addr_q;
        if ((state_q == ST_RST_WAIT) && wait_rst_done) begin
            addr_d = '0;
        end else if (step && !at_last) begin
            addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 32'd0;
            addr_q    <= '0;
            lcd_rst_q <= 1'b0;
            valid_q   <= 1'b0;
            byte_q    <= 8'h00;
            dc_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            addr_q <= addr_d;
            if (step) begin
                valid_q <= 1'b0;
                if (at_last) begin
                    state_q <= ST_READY;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= ST_FETCH;
                end
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_q   <= ST_RST_LO;
                            cnt_q     <= cycles_to_load(32'(RST_LOW_CYC));
                            busy_q    <= 1'b1;
                            lcd_rst_q <= 1'b0;
                        end
                    end
                    ST_RST_LO: begin
                        if (cnt_q == 32'd0) begin
                            state_q   <= ST_RST_WAIT;
                            lcd_rst_q <= 1'b1;
                            cnt_q     <= cycles_to_load(32'(RST_WAIT_CYC));
                        end else begin
                            cnt_q <= cnt_q - 32'd1;
                        end
                    end
                    ST_RST_WAIT: begin
                        if (wait_rst_done) begin
                            state_q <= ST_FETCH;
                        end else begin
                            cnt_q <= cnt_q - 32'd1;
                        end
                    end
                    ST_FETCH: begin
                        case (kind)
                            KIND_CMD, KIND_DATA: begin
                                state_q <= ST_SEND;
                                valid_q <= 1'b1;
                                byte_q  <= payload;
                                dc_q    <= (kind == KIND_DATA);
                            end
                            KIND_DELAY: begin
                                state_q <= ST_WAIT_MS;
                                cnt_q   <= cycles_to_load(delay_cyc);
                            end
                            default: begin
                                state_q <= ST_READY;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        endcase
                    end
                    ST_WAIT_MS: begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                    ST_READY: begin
                        if (start && !px_valid) begin
                            state_q   <= ST_RST_LO;
                            cnt_q     <= cycles_to_load(32'(RST_LOW_CYC));
                            busy_q    <= 1'b1;
                            done_q    <= 1'b0;
                            lcd_rst_q <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // In READY the serializer belongs to the pixel source; pixel bytes are always data.
    assign lcd_rst  = lcd_rst_q;
    assign tx_valid = done_q ? px_valid : valid_q;
    assign tx_byte  = done_q ? px_byte  : byte_q;
    assign tx_dc    = done_q ? 1'b1     : dc_q;
    assign px_ready = done_q & tx_ready;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Directed bench for lcd_init_sequencer: reset, init stream, stall, abort, pass-through,
// plus a second instance with an 8-entry ROM (no END) to exercise the address-limit exit.
module tb_lcd_init_sequencer;

    localparam int RST_LOW  = 140;
    localparam int RST_WAIT = 20;
    localparam int MS       = 10;

`ifdef LCD_SEQ_DELAY_EN
    localparam int W_EFF = RST_WAIT;
    localparam int D1    = 120 * MS;
    localparam int D2    = 10 * MS;
`else
    localparam int W_EFF = 1;
    localparam int D1    = 1;
    localparam int D2    = 1;
`endif
    localparam int EXP_RISE  = 1 + RST_LOW;
    localparam int EXP_FIRST = EXP_RISE + W_EFF + 1;
    localparam int EXP_GAP   = D1 + 2;
    localparam int EXP_DONE  = EXP_FIRST + D1 + D2 + 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       lcd_rst;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_byte;
    logic       tx_dc;
    logic       px_valid;
    logic       px_ready;
    logic [7:0] px_byte;
    logic       busy;
    logic       done;

    logic       start2;
    logic       lcd_rst2;
    logic       tx_valid2;
    logic       tx_ready2 = 1'b1;
    logic [7:0] tx_byte2;
    logic       tx_dc2;
    logic       px_valid2 = 1'b0;
    logic       px_ready2;
    logic [7:0] px_byte2 = 8'h00;
    logic       busy2;
    logic       done2;

    int nChecks = 0;
    int nBad    = 0;
    int cyc     = 0;
    int startCyc;
    int doneCyc;

    logic       capEn = 1'b0;
    logic [7:0] capByte[$];
    logic       capDc[$];
    int         capCyc[$];
    int         firstValidCyc;
    int         riseCyc;
    int         lowCnt;
    int         validEarly;
    int         pxEarly;
    int         unstable;
    logic       holdPend;
    logic [7:0] holdByte;
    logic       holdDc;
    int         hs2 = 0;
    logic [7:0] last2 = 8'h00;

    logic [7:0] expB[7] = '{8'h11, 8'h3A, 8'h55, 8'h36, 8'h00, 8'h21, 8'h29};
    logic       expD[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    lcd_init_sequencer #(
        .RST_LOW_CYC  (RST_LOW),
        .RST_WAIT_CYC (RST_WAIT),
        .MS_CYC       (MS),
        .ROM_AW       (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .lcd_rst  (lcd_rst),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_byte  (tx_byte),
        .tx_dc    (tx_dc),
        .px_valid (px_valid),
        .px_ready (px_ready),
        .px_byte  (px_byte),
        .busy     (busy),
        .done     (done)
    );

    lcd_init_sequencer #(
        .RST_LOW_CYC  (4),
        .RST_WAIT_CYC (RST_WAIT),
        .MS_CYC       (MS),
        .ROM_AW       (3)
    ) dut2 (
        .clk      (clk),
        .rst      (rst),
        .start    (start2),
        .lcd_rst  (lcd_rst2),
        .tx_valid (tx_valid2),
        .tx_ready (tx_ready2),
        .tx_byte  (tx_byte2),
        .tx_dc    (tx_dc2),
        .px_valid (px_valid2),
        .px_ready (px_ready2),
        .px_byte  (px_byte2),
        .busy     (busy2),
        .done     (done2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe both instances mid-cycle; inputs only change just after a rising edge.
    always @(negedge clk) begin
        if (capEn) begin
            if (tx_valid && tx_ready && !done) begin
                capByte.push_back(tx_byte);
                capDc.push_back(tx_dc);
                capCyc.push_back(cyc);
            end
            if (tx_valid && !done && firstValidCyc < 0) firstValidCyc = cyc;
            if (busy && !lcd_rst) lowCnt++;
            if (busy && lcd_rst && riseCyc < 0) riseCyc = cyc;
            if (busy && tx_valid && riseCyc < 0) validEarly++;
            if (px_ready && !done) pxEarly++;
            if (holdPend && tx_valid && (tx_byte != holdByte || tx_dc != holdDc)) unstable++;
            holdPend = tx_valid && !tx_ready;
            holdByte = tx_byte;
            holdDc   = tx_dc;
        end
        if (tx_valid2 && tx_ready2 && !done2) begin
            hs2++;
            last2 = tx_byte2;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nBad++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
        end
    endtask

    // Pulses start (and optionally start2) for one cycle; startCyc is the cycle it is high.
    task automatic applyStimulus(input logic withSecond);
        @(posedge clk);
        #1;
        start    = 1'b1;
        start2   = withSecond;
        startCyc = cyc;
        @(posedge clk);
        #1;
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic clearCap();
        capByte.delete();
        capDc.delete();
        capCyc.delete();
        firstValidCyc = -1;
        riseCyc       = -1;
        lowCnt        = 0;
        validEarly    = 0;
        pxEarly       = 0;
        unstable      = 0;
        holdPend      = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        doneCyc = cyc;
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    task automatic waitByte(input string tag, input logic [7:0] b, input int budget);
        int n = 0;
        while (!(tx_valid && tx_byte == b) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(tag, 32'(tx_valid && tx_byte == b), 32'd1);
    endtask

    task automatic compareStream(input string tag);
        logic [31:0] act;
        checkOutput({tag, "_count"}, 32'(capByte.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            act = (i < capByte.size()) ? {23'd0, capDc[i], capByte[i]} : 32'hFFFF;
            checkOutput($sformatf("%s_b%0d", tag, i), act, {23'd0, expD[i], expB[i]});
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, want test end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        start2   = 1'b0;
        tx_ready = 1'b1;
        px_valid = 1'b1;
        px_byte  = 8'h5A;
        clearCap();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_lcd_rst",  32'(lcd_rst),  32'd0);
        checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_tx_byte",  32'(tx_byte),  32'd0);
        checkOutput("rst_tx_dc",    32'(tx_dc),    32'd0);
        checkOutput("rst_busy",     32'(busy),     32'd0);
        checkOutput("rst_done",     32'(done),     32'd0);
        checkOutput("rst_px_ready", 32'(px_ready), 32'd0);

        px_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Full sequence with the serializer always ready.
        clearCap();
        capEn = 1'b1;
        applyStimulus(1'b1);
        checkOutput("A_busy_cyc1",    32'(busy),    32'd1);
        checkOutput("A_lcd_rst_cyc1", 32'(lcd_rst), 32'd0);
        waitDone("A_done", 5000);
        checkOutput("A_done_cycle",  32'(doneCyc - startCyc), 32'(EXP_DONE));
        checkOutput("A_busy_at_done", 32'(busy), 32'd0);
        checkOutput("A_rst_low_len", 32'(lowCnt), 32'(RST_LOW));
        checkOutput("A_rise_cycle",  32'(riseCyc - startCyc), 32'(EXP_RISE));
        checkOutput("A_first_valid", 32'(firstValidCyc - startCyc), 32'(EXP_FIRST));
        checkOutput("A_valid_early", 32'(validEarly), 32'd0);
        checkOutput("A_px_early",    32'(pxEarly), 32'd0);
        compareStream("A_stream");
        checkOutput("A_delay_gap",
                    32'((capCyc.size() > 1) ? capCyc[1] - capCyc[0] - 1 : -1), 32'(EXP_GAP));
        checkOutput("A_byte_gap",
                    32'((capCyc.size() > 2) ? capCyc[2] - capCyc[1] - 1 : -1), 32'd1);

        for (int n = 0; n < 5000 && !done2; n++) begin
            @(posedge clk);
            #1;
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput("W_done",      32'(done2),     32'd1);
        checkOutput("W_busy",      32'(busy2),     32'd0);
        checkOutput("W_hs_count",  32'(hs2),       32'd7);
        checkOutput("W_last_byte", 32'(last2),     32'h29);
        checkOutput("W_no_replay", 32'(tx_valid2), 32'd0);
        checkOutput("W_lcd_rst",   32'(lcd_rst2),  32'd1);
        checkOutput("W_px_ready",  32'(px_ready2), 32'd1);
        checkOutput("W_tx_dc",     32'(tx_dc2),    32'd1);

        // Pixel pass-through in READY.
        px_valid = 1'b1;
        px_byte  = 8'hA5;
        tx_ready = 1'b1;
        #1;
        checkOutput("P_tx_valid", 32'(tx_valid), 32'd1);
        checkOutput("P_tx_byte",  32'(tx_byte),  32'hA5);
        checkOutput("P_tx_dc",    32'(tx_dc),    32'd1);
        checkOutput("P_px_ready", 32'(px_ready), 32'd1);
        tx_ready = 1'b0;
        #1;
        checkOutput("P_px_ready_lo", 32'(px_ready), 32'd0);
        applyStimulus(1'b0);
        checkOutput("P_start_ign_done", 32'(done), 32'd1);
        checkOutput("P_start_ign_busy", 32'(busy), 32'd0);
        px_valid = 1'b0;
        tx_ready = 1'b1;

        // Restart from READY and stall the 0x3A handshake for five cycles.
        clearCap();
        applyStimulus(1'b0);
        checkOutput("B_busy", 32'(busy), 32'd1);
        checkOutput("B_done", 32'(done), 32'd0);
        waitByte("B_see_3A", 8'h3A, 3000);
        tx_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("B_hold_valid", 32'(tx_valid), 32'd1);
        checkOutput("B_hold_byte",  32'(tx_byte),  32'h3A);
        checkOutput("B_hold_dc",    32'(tx_dc),    32'd0);
        tx_ready = 1'b1;
        waitDone("B_done_end", 5000);
        checkOutput("B_unstable", 32'(unstable), 32'd0);
        compareStream("B_stream");
        checkOutput("B_stall_gap",
                    32'((capCyc.size() > 1) ? capCyc[1] - capCyc[0] - 1 : -1), 32'(EXP_GAP + 5));

        // Abort with reset while 0x55 is pending, then replay from the start.
        clearCap();
        applyStimulus(1'b0);
        waitByte("C_see_55", 8'h55, 3000);
        tx_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("C_valid_drop", 32'(tx_valid), 32'd0);
        checkOutput("C_busy",       32'(busy),     32'd0);
        checkOutput("C_lcd_rst",    32'(lcd_rst),  32'd0);
        checkOutput("C_tx_byte",    32'(tx_byte),  32'd0);
        @(negedge clk);
        rst      = 1'b1;
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("C_idle", 32'(busy), 32'd0);
        clearCap();
        applyStimulus(1'b0);
        waitDone("C_done", 5000);
        compareStream("C_stream");
        checkOutput("C_rst_low_len", 32'(lowCnt), 32'(RST_LOW));

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
